// File: rtl/ecc_76_bist_sched.sv
// ecc_76_bist_sched
// Built-in self-test scheduler for the 76-bit SECDED decoder. One decoder
// instance is time-shared between functional reads (always first) and a
// three-step golden-codeword test (clean, one flipped bit, two flipped bits)
// that only uses idle decoder slots. The pass/fail status is sticky until reset.
module ecc_76_bist_sched #(
   parameter int                      DATA_WIDTH   = 76,
   parameter int                      PARITY_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0]   GOLD_DATA    = 76'h5_A5A5_A5A5_A5A5_A5A5_A5,
   parameter logic [PARITY_WIDTH-1:0] GOLD_PARITY  = 8'h00,
   parameter int                      INTV_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_en,
   input  logic [INTV_W-1:0]       cfg_interval,
   input  logic                    bist_start,
   input  logic                    func_vld,
   input  logic [DATA_WIDTH-1:0]   func_data,
   input  logic [PARITY_WIDTH-1:0] func_parity,
   output logic [DATA_WIDTH-1:0]   dec_data_in,
   output logic [PARITY_WIDTH-1:0] dec_parity_in,
   output logic                    dec_bypass,
   output logic                    dec_fault_detc_en,
   input  logic [DATA_WIDTH-1:0]   dec_data_out,
   input  logic                    dec_sbit_err,
   input  logic                    dec_dbit_err,
   input  logic                    dec_ecc_fault,
   output logic                    func_out_vld,
   output logic [DATA_WIDTH-1:0]   func_out_data,
   output logic                    func_sbit_err,
   output logic                    func_dbit_err,
   output logic                    func_ecc_fault,
   output logic                    bist_busy,
   output logic                    bist_done,
   output logic                    bist_fail,
   output logic [3:0]              bist_fail_code,
   output logic [7:0]              bist_pass_cnt
);

   localparam int              IDX_W     = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 2);
   localparam logic [INTV_W-1:0] INTV_ONE = INTV_W'(1);

   // Slot tag kinds and test step ids carried from issue to check stage
   localparam logic [1:0] TAG_NONE   = 2'd0;
   localparam logic [1:0] TAG_FUNC   = 2'd1;
   localparam logic [1:0] TAG_TEST   = 2'd2;
   localparam logic [1:0] STEP_CLEAN = 2'd0;
   localparam logic [1:0] STEP_SBIT  = 2'd1;
   localparam logic [1:0] STEP_DBIT  = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      T_CLEAN,
      T_SBIT,
      T_DBIT,
      DRAIN
   } state_t;

   state_t                  state_reg, state_next;
   logic [INTV_W-1:0]       intv_cnt_reg, intv_cnt_next;
   logic [IDX_W-1:0]        inj_idx_reg;

   logic [DATA_WIDTH-1:0]   sbit_mask;
   logic [DATA_WIDTH-1:0]   dbit_mask;
   logic                    test_slot;
   logic [1:0]              test_step;
   logic [DATA_WIDTH-1:0]   test_data;

   logic [DATA_WIDTH-1:0]   dec_data_reg;
   logic [PARITY_WIDTH-1:0] dec_parity_reg;
   logic                    dec_en_reg;
   logic [1:0]              tag_kind_reg;
   logic [1:0]              tag_step_reg;

   logic                    func_out_vld_reg;
   logic [DATA_WIDTH-1:0]   func_out_data_reg;
   logic                    func_sbit_reg;
   logic                    func_dbit_reg;
   logic                    func_fault_reg;

   logic                    data_ok;
   logic [3:0]              step_err;
   logic [3:0]              run_err_reg;
   logic [3:0]              run_err_final;
   logic                    check_live;
   logic                    run_complete;

   logic                    bist_done_reg;
   logic                    bist_fail_reg;
   logic [3:0]              bist_fail_code_reg;
   logic [7:0]              bist_pass_cnt_reg;

   // Injection masks: one-hot at inj_idx, and the adjacent pair idx/idx+1
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
         assign sbit_mask[gi] = (inj_idx_reg == IDX_W'(gi));
         if (gi == 0) begin : g_lsb
            assign dbit_mask[gi] = sbit_mask[gi];
         end else begin : g_upper
            assign dbit_mask[gi] = sbit_mask[gi] | sbit_mask[gi-1];
         end
      end
   endgenerate

   assign bist_busy = (state_reg == T_CLEAN) || (state_reg == T_SBIT) ||
                      (state_reg == T_DBIT)  || (state_reg == DRAIN);

   // A test slot issues only from a T_* state when functional traffic is absent
   assign test_slot = cfg_en && !func_vld &&
                      ((state_reg == T_CLEAN) || (state_reg == T_SBIT) || (state_reg == T_DBIT));

   // Test pattern for the current step
   always_comb begin
      test_step = STEP_CLEAN;
      test_data = GOLD_DATA;
      case (state_reg)
         T_SBIT: begin
            test_step = STEP_SBIT;
            test_data = GOLD_DATA ^ sbit_mask;
         end
         T_DBIT: begin
            test_step = STEP_DBIT;
            test_data = GOLD_DATA ^ dbit_mask;
         end
         default: ;
      endcase
   end

   // Scheduler next-state and interval counter
   always_comb begin
      state_next    = state_reg;
      intv_cnt_next = intv_cnt_reg;
      if (!cfg_en) begin
         state_next    = IDLE;
         intv_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               intv_cnt_next = '0;
               if (bist_start) begin
                  state_next = T_CLEAN;
               end else if (cfg_interval != '0) begin
                  state_next = WAIT;
               end
            end
            WAIT: begin
               if (bist_start) begin
                  state_next    = T_CLEAN;
                  intv_cnt_next = '0;
               end else if (cfg_interval == '0) begin
                  state_next    = IDLE;
                  intv_cnt_next = '0;
               end else if (intv_cnt_reg >= cfg_interval - INTV_ONE) begin
                  state_next    = T_CLEAN;
                  intv_cnt_next = '0;
               end else begin
                  intv_cnt_next = intv_cnt_reg + INTV_ONE;
               end
            end
            T_CLEAN: if (!func_vld) state_next = T_SBIT;
            T_SBIT:  if (!func_vld) state_next = T_DBIT;
            T_DBIT:  if (!func_vld) state_next = DRAIN;
            DRAIN: begin
               intv_cnt_next = '0;
               state_next    = (cfg_interval != '0) ? WAIT : IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Scheduler state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         intv_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         intv_cnt_reg <= intv_cnt_next;
      end
   end

   // Issue stage: functional word wins, otherwise the pending test step
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_data_reg   <= '0;
         dec_parity_reg <= '0;
         dec_en_reg     <= 1'b0;
         tag_kind_reg   <= TAG_NONE;
         tag_step_reg   <= STEP_CLEAN;
      end else if (func_vld) begin
         dec_data_reg   <= func_data;
         dec_parity_reg <= func_parity;
         dec_en_reg     <= 1'b1;
         tag_kind_reg   <= TAG_FUNC;
         tag_step_reg   <= STEP_CLEAN;
      end else if (test_slot) begin
         dec_data_reg   <= test_data;
         dec_parity_reg <= GOLD_PARITY;
         dec_en_reg     <= 1'b1;
         tag_kind_reg   <= TAG_TEST;
         tag_step_reg   <= test_step;
      end else begin
         dec_en_reg     <= 1'b0;
         tag_kind_reg   <= TAG_NONE;
      end
   end

   assign dec_data_in       = dec_data_reg;
   assign dec_parity_in     = dec_parity_reg;
   assign dec_fault_detc_en = dec_en_reg;
   assign dec_bypass        = 1'b0;

   // Check stage, functional side: register decoder result for the requester
   always_ff @(posedge clk) begin
      if (rst) begin
         func_out_vld_reg  <= 1'b0;
         func_out_data_reg <= '0;
         func_sbit_reg     <= 1'b0;
         func_dbit_reg     <= 1'b0;
         func_fault_reg    <= 1'b0;
      end else begin
         func_out_vld_reg <= (tag_kind_reg == TAG_FUNC);
         if (tag_kind_reg == TAG_FUNC) begin
            func_out_data_reg <= dec_data_out;
            func_sbit_reg     <= dec_sbit_err;
            func_dbit_reg     <= dec_dbit_err;
            func_fault_reg    <= dec_ecc_fault;
         end
      end
   end

   assign func_out_vld   = func_out_vld_reg;
   assign func_out_data  = func_out_data_reg;
   assign func_sbit_err  = func_sbit_reg;
   assign func_dbit_err  = func_dbit_reg;
   assign func_ecc_fault = func_fault_reg;

   // Per-step mismatch against the expected decoder response
   assign data_ok = (dec_data_out == GOLD_DATA);

   always_comb begin
      step_err = 4'b0000;
      case (tag_step_reg)
         STEP_CLEAN: step_err[0] = dec_sbit_err | dec_dbit_err | ~data_ok;
         STEP_SBIT:  step_err[1] = ~dec_sbit_err | dec_dbit_err | ~data_ok;
         default:    step_err[2] = ~dec_dbit_err | dec_sbit_err;
      endcase
      step_err[3] = dec_ecc_fault;
   end

   // A test check counts only while the run it belongs to is still alive
   assign check_live    = cfg_en && (tag_kind_reg == TAG_TEST) &&
                          ((state_reg == T_SBIT) || (state_reg == T_DBIT) || (state_reg == DRAIN));
   assign run_complete  = check_live && (tag_step_reg == STEP_DBIT);
   assign run_err_final = run_err_reg | step_err;

   // Run accumulation and sticky status; the DBIT check closes the run
   always_ff @(posedge clk) begin
      if (rst) begin
         run_err_reg        <= '0;
         bist_done_reg      <= 1'b0;
         bist_fail_reg      <= 1'b0;
         bist_fail_code_reg <= '0;
         bist_pass_cnt_reg  <= '0;
         inj_idx_reg        <= '0;
      end else begin
         bist_done_reg <= 1'b0;
         if (!cfg_en) begin
            run_err_reg <= '0;
         end else if (run_complete) begin
            bist_done_reg <= 1'b1;
            run_err_reg   <= '0;
            if (run_err_final != 4'b0000) begin
               bist_fail_reg      <= 1'b1;
               bist_fail_code_reg <= bist_fail_code_reg | run_err_final;
            end else if (bist_pass_cnt_reg != 8'hFF) begin
               bist_pass_cnt_reg <= bist_pass_cnt_reg + 8'd1;
            end
            inj_idx_reg <= (inj_idx_reg == IDX_LAST) ? '0 : inj_idx_reg + IDX_W'(1);
         end else if (check_live) begin
            run_err_reg <= run_err_reg | step_err;
         end
      end
   end

   assign bist_done      = bist_done_reg;
   assign bist_fail      = bist_fail_reg;
   assign bist_fail_code = bist_fail_code_reg;
   assign bist_pass_cnt  = bist_pass_cnt_reg;

endmodule

// File: tb/tb_ecc_76_bist_sched.sv
// tb_ecc_76_bist_sched: scoreboard bench with a behavioural SECDED decoder
// stand-in that recognises the golden codeword and passes functional flags.
module tb_ecc_76_bist_sched;

   localparam int DW = 76;
   localparam int PW = 8;
   localparam int IW = 16;
   localparam logic [DW-1:0] GOLD = 76'h5_A5A5_A5A5_A5A5_A5A5_A5;
   localparam logic [PW-1:0] GPAR = 8'h00;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          s;
      logic          d;
      logic          f;
      logic [31:0]   stamp;
   } func_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_en = 1'b0;
   logic [IW-1:0] cfg_interval = '0;
   logic          bist_start = 1'b0;
   logic          func_vld = 1'b0;
   logic [DW-1:0] func_data = '0;
   logic [PW-1:0] func_parity = '0;
   logic [DW-1:0] dec_data_in;
   logic [PW-1:0] dec_parity_in;
   logic          dec_bypass;
   logic          dec_fault_detc_en;
   logic [DW-1:0] dec_data_out;
   logic          dec_sbit_err;
   logic          dec_dbit_err;
   logic          dec_ecc_fault;
   logic          func_out_vld;
   logic [DW-1:0] func_out_data;
   logic          func_sbit_err;
   logic          func_dbit_err;
   logic          func_ecc_fault;
   logic          bist_busy;
   logic          bist_done;
   logic          bist_fail;
   logic [3:0]    bist_fail_code;
   logic [7:0]    bist_pass_cnt;

   logic          force_sbit_low = 1'b0;
   logic          force_ecc_clean = 1'b0;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            exp_pass = 0;
   int            exp_idx = 0;
   logic [3:0]    exp_code = 4'b0000;
   logic          exp_fail = 1'b0;

   logic [DW-1:0] exp_issue_q[$];
   func_exp_t     func_q[$];

   ecc_76_bist_sched dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_interval(cfg_interval),
      .bist_start(bist_start), .func_vld(func_vld), .func_data(func_data),
      .func_parity(func_parity), .dec_data_in(dec_data_in), .dec_parity_in(dec_parity_in),
      .dec_bypass(dec_bypass), .dec_fault_detc_en(dec_fault_detc_en),
      .dec_data_out(dec_data_out), .dec_sbit_err(dec_sbit_err), .dec_dbit_err(dec_dbit_err),
      .dec_ecc_fault(dec_ecc_fault), .func_out_vld(func_out_vld), .func_out_data(func_out_data),
      .func_sbit_err(func_sbit_err), .func_dbit_err(func_dbit_err),
      .func_ecc_fault(func_ecc_fault), .bist_busy(bist_busy), .bist_done(bist_done),
      .bist_fail(bist_fail), .bist_fail_code(bist_fail_code), .bist_pass_cnt(bist_pass_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Decoder stand-in: golden parity -> count flipped bits vs GOLD; otherwise
   // functional words carry their expected flags in parity[2:0]
   logic [DW-1:0] diff;
   int            nflip;
   always_comb begin
      dec_data_out  = dec_data_in;
      dec_sbit_err  = 1'b0;
      dec_dbit_err  = 1'b0;
      dec_ecc_fault = 1'b0;
      diff          = dec_data_in ^ GOLD;
      nflip         = $countones(diff);
      if (dec_parity_in == GPAR) begin
         if (nflip == 0) begin
            dec_ecc_fault = force_ecc_clean;
         end else if (nflip == 1) begin
            dec_sbit_err = ~force_sbit_low;
            dec_data_out = GOLD;
         end else begin
            dec_dbit_err = 1'b1;
         end
      end else begin
         dec_sbit_err  = dec_parity_in[0];
         dec_dbit_err  = dec_parity_in[1];
         dec_ecc_fault = dec_parity_in[2];
      end
   end

   // Expected issue words of one run at injection index idx
   task automatic push_run(input int idx);
      logic [DW-1:0] one;
      one = 1;
      exp_issue_q.push_back(GOLD);
      exp_issue_q.push_back(GOLD ^ (one << idx));
      exp_issue_q.push_back(GOLD ^ ((one << idx) | (one << (idx + 1))));
   endtask

   // Reference status update for one completed run
   task automatic advance_model(input logic [3:0] err);
      if (err != 4'b0000) begin
         exp_fail = 1'b1;
         exp_code = exp_code | err;
      end else if (exp_pass < 255) begin
         exp_pass = exp_pass + 1;
      end
      exp_idx = (exp_idx == DW - 2) ? 0 : exp_idx + 1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bist_busy, bist_done, bist_fail, func_out_vld, dec_fault_detc_en, dec_bypass} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b done=%b fail=%b fvld=%b en=%b byp=%b, want all 0",
                  bist_busy, bist_done, bist_fail, func_out_vld, dec_fault_detc_en, dec_bypass);
      end
      checks++;
      if (bist_fail_code !== 4'b0 || bist_pass_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_status: code=%b pass=%0d, want 0/0", bist_fail_code, bist_pass_cnt);
      end
      checks++;
      if (dec_data_in !== '0 || dec_parity_in !== '0 || func_out_data !== '0 ||
          {func_sbit_err, func_dbit_err, func_ecc_fault} !== 3'b0) begin
         errors++;
         $display("FAIL reset_data: dec=%h/%h fout=%h, want 0", dec_data_in, dec_parity_in, func_out_data);
      end
      rst    = 1'b0;
      cfg_en = 1'b1;
      @(posedge clk);
      #1;
      $display("reset released at cycle %0d", cyc);
   endtask

   // One manual run on an otherwise idle bench, err = expected fail code bits
   task automatic test_bist_run(input string name, input logic [3:0] err);
      int            c0;
      int            done_cyc;
      int            n;
      logic [DW-1:0] w;
      push_run(exp_idx);
      c0         = cyc;
      done_cyc   = -1;
      n          = 0;
      bist_start = 1'b1;
      for (int k = 0; k < 12 && done_cyc < 0; k++) begin
         @(posedge clk);
         #1;
         bist_start = 1'b0;
         if (dec_fault_detc_en) begin
            checks++;
            if (exp_issue_q.size() == 0) begin
               errors++;
               $display("FAIL %s issue_extra: data=%h at cycle %0d, want none", name, dec_data_in, cyc);
            end else begin
               w = exp_issue_q.pop_front();
               if (dec_data_in !== w || dec_parity_in !== GPAR || cyc != c0 + 2 + n) begin
                  errors++;
                  $display("FAIL %s issue%0d: data=%h par=%h cyc=%0d, want data=%h par=%h cyc=%0d",
                           name, n, dec_data_in, dec_parity_in, cyc - c0, w, GPAR, 2 + n);
               end
            end
            n++;
         end
         if (bist_done) done_cyc = cyc;
      end
      checks++;
      if (done_cyc != c0 + 5) begin
         errors++;
         $display("FAIL %s done_latency: got %0d, want 5", name, done_cyc - c0);
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL %s issue_count: got %0d, want 3", name, n);
      end
      advance_model(err);
      checks++;
      if (bist_fail !== exp_fail || bist_fail_code !== exp_code) begin
         errors++;
         $display("FAIL %s status: fail=%b code=%b, want fail=%b code=%b",
                  name, bist_fail, bist_fail_code, exp_fail, exp_code);
      end
      checks++;
      if (bist_pass_cnt !== exp_pass[7:0] || bist_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s pass_busy: pass=%0d busy=%b, want pass=%0d busy=0",
                  name, bist_pass_cnt, bist_busy, exp_pass);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bist_done !== 1'b0) begin
         errors++;
         $display("FAIL %s done_width: done=%b, want 0", name, bist_done);
      end
      exp_issue_q.delete();
      $display("run %s: done at +%0d, fail=%b code=%b pass=%0d", name, done_cyc - c0,
               bist_fail, bist_fail_code, bist_pass_cnt);
   endtask

   task automatic test_single_run();
      test_bist_run("single", 4'b0000);
   endtask

   // 20 back-to-back functional words overlapping a run request
   task automatic test_back_to_back();
      int            c0;
      int            done_cyc;
      int            n;
      logic [DW-1:0] base;
      logic [DW-1:0] w;
      func_exp_t     e;
      base     = {12'hABC, 64'h0123_4567_89AB_0000};
      c0       = cyc;
      done_cyc = -1;
      n        = 0;
      push_run(exp_idx);
      for (int j = 0; j < 30; j++) begin
         if (j == 0 || j == 5) bist_start = 1'b1;
         if (j < 20) begin
            func_vld    = 1'b1;
            func_data   = base + DW'(j);
            func_parity = {5'b10000, j[2:0]};
            e.data  = base + DW'(j);
            e.s     = j[0];
            e.d     = j[1];
            e.f     = j[2];
            e.stamp = cyc;
            func_q.push_back(e);
         end else begin
            func_vld = 1'b0;
         end
         @(posedge clk);
         #1;
         bist_start = 1'b0;
         if (func_out_vld) begin
            checks++;
            if (func_q.size() == 0) begin
               errors++;
               $display("FAIL func_extra: data=%h at cycle %0d, want none", func_out_data, cyc);
            end else begin
               e = func_q.pop_front();
               if (func_out_data !== e.data || {func_sbit_err, func_dbit_err, func_ecc_fault} !== {e.s, e.d, e.f} ||
                   cyc != int'(e.stamp) + 2) begin
                  errors++;
                  $display("FAIL func_out: data=%h flags=%b lat=%0d, want data=%h flags=%b lat=2",
                           func_out_data, {func_sbit_err, func_dbit_err, func_ecc_fault},
                           cyc - int'(e.stamp), e.data, {e.s, e.d, e.f});
               end else begin
                  $display("func word %h out at cycle %0d", func_out_data, cyc);
               end
            end
         end
         if (dec_fault_detc_en && dec_parity_in === GPAR) begin
            checks++;
            if (exp_issue_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_issue_extra: data=%h at cycle %0d, want none", dec_data_in, cyc);
            end else begin
               w = exp_issue_q.pop_front();
               if (dec_data_in !== w || cyc != c0 + 21 + n) begin
                  errors++;
                  $display("FAIL b2b_issue%0d: data=%h cyc=+%0d, want data=%h cyc=+%0d",
                           n, dec_data_in, cyc - c0, w, 21 + n);
               end
            end
            n++;
         end
         if (bist_done) done_cyc = cyc;
      end
      checks++;
      if (func_q.size() != 0 || exp_issue_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_leftover: func=%0d issue=%0d, want 0/0", func_q.size(), exp_issue_q.size());
      end
      checks++;
      if (done_cyc != c0 + 24) begin
         errors++;
         $display("FAIL b2b_done: got +%0d, want +24", done_cyc - c0);
      end
      advance_model(4'b0000);
      checks++;
      if (bist_pass_cnt !== exp_pass[7:0] || bist_busy !== 1'b0 || bist_fail !== exp_fail) begin
         errors++;
         $display("FAIL b2b_status: pass=%0d busy=%b fail=%b, want pass=%0d busy=0 fail=%b",
                  bist_pass_cnt, bist_busy, bist_fail, exp_pass, exp_fail);
      end
      func_q.delete();
      exp_issue_q.delete();
   endtask

   task automatic test_sbit_fault();
      force_sbit_low = 1'b1;
      test_bist_run("sbit_fault", 4'b0010);
      force_sbit_low = 1'b0;
      test_bist_run("sticky", 4'b0000);
   endtask

   task automatic test_ecc_fault();
      force_ecc_clean = 1'b1;
      test_bist_run("ecc_fault", 4'b1000);
      force_ecc_clean = 1'b0;
   endtask

   // Drop cfg_en while the SBIT step is pending
   task automatic test_abort();
      bist_start = 1'b1;
      @(posedge clk);
      #1;
      bist_start = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (dec_fault_detc_en !== 1'b1 || dec_data_in !== GOLD || bist_busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_clean_issue: en=%b data=%h busy=%b, want 1/%h/1",
                  dec_fault_detc_en, dec_data_in, bist_busy, GOLD);
      end
      cfg_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bist_done !== 1'b0 || bist_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: done=%b busy=%b at +%0d, want 0/0", bist_done, bist_busy, k);
         end
      end
      checks++;
      if (bist_pass_cnt !== exp_pass[7:0] || bist_fail_code !== exp_code || bist_fail !== exp_fail) begin
         errors++;
         $display("FAIL abort_status: pass=%0d code=%b fail=%b, want %0d/%b/%b",
                  bist_pass_cnt, bist_fail_code, bist_fail, exp_pass, exp_code, exp_fail);
      end
      cfg_en = 1'b1;
      @(posedge clk);
      #1;
      $display("abort: run discarded, pass=%0d code=%b", bist_pass_cnt, bist_fail_code);
   endtask

   // Automatic runs every 10 idle cycles; pass count saturation and idx wrap
   task automatic test_interval();
      int            runs;
      int            last_done;
      logic [DW-1:0] w;
      runs      = 0;
      last_done = -1;
      exp_issue_q.delete();
      push_run(exp_idx);
      cfg_interval = 16'd10;
      for (int k = 0; k < 300 * 14 + 100 && runs < 300; k++) begin
         @(posedge clk);
         #1;
         if (dec_fault_detc_en) begin
            checks++;
            if (exp_issue_q.size() == 0) begin
               errors++;
               $display("FAIL intv_issue_extra: data=%h at cycle %0d, want none", dec_data_in, cyc);
            end else begin
               w = exp_issue_q.pop_front();
               if (dec_data_in !== w) begin
                  errors++;
                  $display("FAIL intv_issue run%0d: data=%h, want %h", runs, dec_data_in, w);
               end
            end
         end
         if (bist_done) begin
            runs++;
            advance_model(4'b0000);
            checks++;
            if (bist_pass_cnt !== exp_pass[7:0]) begin
               errors++;
               $display("FAIL intv_pass run%0d: got %0d, want %0d", runs, bist_pass_cnt, exp_pass);
            end
            if (last_done >= 0) begin
               checks++;
               if (cyc - last_done != 14) begin
                  errors++;
                  $display("FAIL intv_period run%0d: got %0d, want 14", runs, cyc - last_done);
               end
            end
            last_done = cyc;
            $display("auto run %0d done at cycle %0d pass=%0d next_idx=%0d", runs, cyc, bist_pass_cnt, exp_idx);
            if (runs < 300) push_run(exp_idx);
            else cfg_en = 1'b0;
         end
      end
      checks++;
      if (runs != 300) begin
         errors++;
         $display("FAIL intv_runs: got %0d, want 300", runs);
      end
      checks++;
      if (bist_pass_cnt !== 8'd255 || bist_fail_code !== exp_code) begin
         errors++;
         $display("FAIL intv_final: pass=%0d code=%b, want 255/%b", bist_pass_cnt, bist_fail_code, exp_code);
      end
      @(posedge clk);
      #1;
      cfg_interval = '0;
      cfg_en       = 1'b1;
      @(posedge clk);
      #1;
      exp_issue_q.delete();
   endtask

   task automatic test_reset_mid_run();
      bist_start = 1'b1;
      @(posedge clk);
      #1;
      bist_start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({bist_busy, bist_done, bist_fail, func_out_vld, dec_fault_detc_en} !== 5'b0 ||
          bist_fail_code !== 4'b0 || bist_pass_cnt !== 8'd0 || dec_data_in !== '0) begin
         errors++;
         $display("FAIL midrun_reset: busy=%b done=%b fail=%b code=%b pass=%0d en=%b, want all 0",
                  bist_busy, bist_done, bist_fail, bist_fail_code, bist_pass_cnt, dec_fault_detc_en);
      end
      rst      = 1'b0;
      exp_pass = 0;
      exp_idx  = 0;
      exp_code = 4'b0000;
      exp_fail = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bist_done !== 1'b0 || bist_busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_after: done=%b busy=%b, want 0/0", bist_done, bist_busy);
      end
      test_bist_run("after_reset", 4'b0000);
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_back_to_back();
      test_sbit_fault();
      test_ecc_fault();
      test_abort();
      test_interval();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
